// File: rtl/egg_run_ctrl.sv
// Run controller for the egg-drop CPU: loads parameters, resets and runs the CPU,
// detects halt, latches results. Optional run timeout under `EGG_RUN_TIMEOUT_EN`.
module egg_run_ctrl #(
  parameter logic [31:0] HALT_PC        = 32'h0000_0040,
  parameter int unsigned HALT_HOLD      = 4,
  parameter int unsigned RST_CYCLES     = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic [15:0] in_data,
  input  logic        is_init_floors,
  input  logic        is_init_resistance,
  input  logic        start,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] result_attempt_count,
  input  logic [31:0] result_broken_count,
  input  logic        result_is_last_broken,
  output logic        cpu_rst,
  output logic [31:0] init_floors,
  output logic [31:0] init_resistance,
  output logic [31:0] disp_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        last_broken,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HALT_HOLD - 1);

  state_t      state_q, state_d;
  logic [15:0] floors_q, floors_d, res_q, res_d;
  logic [15:0] attempt_q, attempt_d, broken_q, broken_d;
  logic        last_q, last_d;
  logic [3:0]  code_q, code_d;
  logic [31:0] cnt_q, cnt_d;
  logic        start_prev_q;
  logic        start_edge;
  logic        cpu_rst_d, busy_d, done_d, error_d;
  logic [31:0] disp_d;
`ifdef EGG_RUN_TIMEOUT_EN
  logic [31:0] run_q, run_d;
`else
  logic        unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  logic unused_bits;
  assign unused_bits = ^{result_attempt_count[31:16], result_broken_count[31:16]};

  assign start_edge = start & ~start_prev_q;

  always_comb begin
    state_d   = state_q;
    floors_d  = floors_q;
    res_d     = res_q;
    attempt_d = attempt_q;
    broken_d  = broken_q;
    last_d    = last_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
`ifdef EGG_RUN_TIMEOUT_EN
    run_d     = run_q;
`endif
    // Parameters are only writable while no run is in flight.
    if (state_q == IDLE || state_q == DONE || state_q == ERR) begin
      if (is_init_floors)          floors_d = in_data;
      else if (is_init_resistance) res_d    = in_data;
    end
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_edge) begin
          attempt_d = '0;
          broken_d  = '0;
          last_d    = 1'b0;
          code_d    = 4'd0;
          cnt_d     = '0;
          if (floors_q == 16'd0) begin
            state_d = ERR;
            code_d  = 4'd1;
          end else begin
            state_d = PREP;
          end
        end
      end
      PREP: begin
        if (cnt_q == RST_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
`ifdef EGG_RUN_TIMEOUT_EN
          run_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RUN: begin
        if (cpu_pc == HALT_PC) begin
          if (cnt_q == HOLD_LAST) begin
            state_d   = DONE;
            cnt_d     = '0;
            attempt_d = result_attempt_count[15:0];
            broken_d  = result_broken_count[15:0];
            last_d    = result_is_last_broken;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end else begin
          cnt_d = '0;
        end
`ifdef EGG_RUN_TIMEOUT_EN
        // A halt seen on the final allowed cycle still wins over the timeout.
        if (state_d == RUN) begin
          if (run_q == TIMEOUT_CYCLES - 32'd1) begin
            state_d = ERR;
            code_d  = 4'd2;
          end else begin
            run_d = run_q + 32'd1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    cpu_rst_d = (state_d == IDLE) || (state_d == PREP) || (state_d == ERR);
    busy_d    = (state_d == PREP) || (state_d == RUN);
    done_d    = (state_d == DONE);
    error_d   = (state_d == ERR);
    case (state_d)
      DONE:    disp_d = {attempt_d, broken_d};
      ERR:     disp_d = {28'hEEEE_000, code_d};
      default: disp_d = {floors_d, res_d};
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q      <= IDLE;
      floors_q     <= '0;
      res_q        <= '0;
      attempt_q    <= '0;
      broken_q     <= '0;
      last_q       <= 1'b0;
      code_q       <= 4'd0;
      cnt_q        <= '0;
      start_prev_q <= 1'b0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      disp_data    <= '0;
`ifdef EGG_RUN_TIMEOUT_EN
      run_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      floors_q     <= floors_d;
      res_q        <= res_d;
      attempt_q    <= attempt_d;
      broken_q     <= broken_d;
      last_q       <= last_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
      start_prev_q <= start;
      cpu_rst      <= cpu_rst_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      disp_data    <= disp_d;
`ifdef EGG_RUN_TIMEOUT_EN
      run_q        <= run_d;
`endif
    end
  end

  assign state           = state_q;
  assign last_broken     = last_q;
  assign init_floors     = {16'd0, floors_q};
  assign init_resistance = {16'd0, res_q};

endmodule

// File: doc/egg_run_ctrl.md
EGG_RUN_CTRL -- requirements
Module: egg_run_ctrl

Interface
REQ-001 Parameter HALT_PC, 32'h0000_0040, instruction address at which the CPU program is considered finished.
REQ-002 Parameter HALT_HOLD, 4, consecutive in_clk cycles cpu_pc must equal HALT_PC to declare completion.
REQ-003 Parameter RST_CYCLES, 16, in_clk cycles cpu_rst is held high before each run.
REQ-004 Parameter TIMEOUT_CYCLES, 32'd50_000_000, in_clk cycles allowed in RUN before timeout.
REQ-005 One clock (in_clk); reset in_rst is synchronous, active-high.
REQ-006 in_clk  input  1  system clock; all state updates on its rising edge.
REQ-007 in_rst  input  1  synchronous active-high reset.
REQ-008 in_data  input  16  switch value for parameter load.
REQ-009 is_init_floors  input  1  level; load in_data as floors.
REQ-010 is_init_resistance  input  1  level; load in_data as resistance.
REQ-011 start  input  1  button level; run begins on rising edge.
REQ-012 cpu_pc  input  32  CPU program counter.
REQ-013 result_attempt_count / result_broken_count  input  32 each  CPU result registers.
REQ-014 result_is_last_broken  input  1  CPU result flag.
REQ-015 cpu_rst  output  1  active-high reset to CPU.
REQ-016 init_floors / init_resistance  output  32 each  zero-extended 16-bit parameters to CPU.
REQ-017 disp_data  output  32  value for seven-segment driver.
REQ-018 busy / done / error  output  1 each  status flags; last_broken  output  1  latched result flag.
REQ-019 state  output  3  current FSM state encoding.

Function
REQ-020 FSM states SHALL be IDLE=0, PREP=1, RUN=2, DONE=3, ERR=4.
REQ-021 Parameter loads SHALL be accepted only in IDLE, DONE, ERR; ignored in PREP/RUN; floors has priority when both load inputs high.
REQ-022 Start edge SHALL be detected with one registered previous-sample; held start SHALL not retrigger.
REQ-023 Start edge in IDLE/DONE/ERR with floors==0 SHALL go to ERR, error code 1; otherwise to PREP.
REQ-024 PREP SHALL assert cpu_rst for exactly RST_CYCLES cycles, then enter RUN with cpu_rst low.
REQ-025 RUN SHALL count consecutive cycles with cpu_pc==HALT_PC; any mismatch clears count; reaching HALT_HOLD enters DONE.
REQ-026 Entering DONE SHALL latch attempt[15:0], broken[15:0], result_is_last_broken in the same cycle.
REQ-027 cpu_rst SHALL be high in IDLE, PREP, ERR; low in RUN and DONE (CPU frozen at halt).
REQ-028 busy SHALL be high in PREP and RUN; done high only in DONE; error high only in ERR.
REQ-029 disp_data SHALL be {floors,resistance} in IDLE/PREP/RUN, {latched attempt,latched broken} in DONE, 32'hEEEE_000n in ERR (n = error code).
REQ-030 All outputs registered; status changes visible the cycle after the triggering edge.
REQ-031 Start edge in DONE/ERR SHALL clear done/error/latched results and begin a new run per REQ-023.

Reset
REQ-032 in_rst SHALL force IDLE, cpu_rst=1, floors=resistance=0, latched results=0, counters=0, busy=done=error=last_broken=0, disp_data=0.
REQ-033 in_rst asserted mid-RUN SHALL abort the run in the same cycle with no results latched.

Configuration
REQ-034 Macro EGG_RUN_TIMEOUT_EN defined: RUN counts cycles; reaching TIMEOUT_CYCLES without halt SHALL enter ERR, error code 2.
REQ-035 Macro undefined: no timeout counter; RUN waits indefinitely for halt.

Verification
REQ-036 Reset, load floors=100, resistance=37, start -> cpu_rst high 16 cycles, RUN, disp_data=0x0064_0025.
REQ-037 In RUN, cpu_pc=HALT_PC 4 cycles, attempt=8, broken=3 -> DONE, disp_data=0x0008_0003, done=1.
REQ-038 cpu_pc=HALT_PC 3 cycles then other, then 4 cycles -> DONE only after the second run of 4.
REQ-039 floors=0, start -> ERR, disp_data=0xEEEE_0001, cpu_rst=1; load changes ignored while RUN.
REQ-040 EGG_RUN_TIMEOUT_EN, TIMEOUT_CYCLES=100, no halt -> ERR code 2 at cycle 100 of RUN.
REQ-041 in_rst mid-RUN -> IDLE next cycle, all outputs at reset values.
